// File: rtl/oisc_sram_arbiter.sv
// Arbitrates the single-port OISC SRAM between the processor FSM and a host port.
// Host wins contested cycles until its burst budget runs out, then the CPU is forced a slot.
module oisc_sram_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int HOST_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_en,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  output logic [DW-1:0] cpu_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic          sram_en,
  output logic          sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_HOST = 2'd2
  } owner_e;

  localparam logic [3:0] BURST = 4'(HOST_BURST);

  owner_e     owner_q, owner_d;
  logic       rd_q, rd_d;
  logic [3:0] hcnt_q, hcnt_d;
  logic       gnt_cpu, gnt_host, contested;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= OWN_NONE;
      rd_q    <= 1'b0;
      hcnt_q  <= 4'd0;
    end else begin
      owner_q <= owner_d;
      rd_q    <= rd_d;
      hcnt_q  <= hcnt_d;
    end
  end

  // Grant, burst counter and owner tracking; reset masks every grant combinationally.
  always_comb begin
    gnt_cpu   = 1'b0;
    gnt_host  = 1'b0;
    contested = cpu_en & host_req;
    hcnt_d    = hcnt_q;
    owner_d   = OWN_NONE;
    rd_d      = 1'b0;

    if (!rst) begin
      if (contested) begin
        if (hcnt_q < BURST) gnt_host = 1'b1;
        else                gnt_cpu  = 1'b1;
      end else if (cpu_en) begin
        gnt_cpu = 1'b1;
      end else if (host_req) begin
        gnt_host = 1'b1;
      end
    end

    if (!host_req) begin
      hcnt_d = 4'd0;
    end else if (contested && gnt_host) begin
      hcnt_d = (hcnt_q >= BURST) ? BURST : hcnt_q + 4'd1;
    end else if (contested && gnt_cpu) begin
      hcnt_d = 4'd0;
    end

    if (gnt_host) begin
      owner_d = OWN_HOST;
      rd_d    = ~host_we;
    end else if (gnt_cpu) begin
      owner_d = OWN_CPU;
      rd_d    = ~cpu_we;
    end
  end

  // With no host grant the CPU fields sit on the bus so an idle SRAM sees stable inputs.
  always_comb begin
    sram_en    = gnt_cpu | gnt_host;
    sram_we    = 1'b0;
    sram_addr  = cpu_addr;
    sram_wdata = cpu_wdata;
    if (gnt_host) begin
      sram_we    = host_we;
      sram_addr  = host_addr;
      sram_wdata = host_wdata;
    end else if (gnt_cpu) begin
      sram_we = cpu_we;
    end
  end

  assign cpu_stall   = cpu_en & ~gnt_cpu;
  assign host_gnt    = gnt_host;
  assign host_rvalid = (owner_q == OWN_HOST) && rd_q && !rst;
  assign host_rdata  = sram_rdata;
  assign cpu_rdata   = sram_rdata;

endmodule

// File: tb/tb_oisc_sram_arbiter.sv
// Directed bench for oisc_sram_arbiter: two instances (HOST_BURST 4 and 1) share stimulus,
// each backed by its own behavioural 1-cycle-latency SRAM.
module tb_oisc_sram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_en, cpu_we, host_req, host_we;
  logic [7:0] cpu_addr, cpu_wdata, host_addr, host_wdata;

  logic       cpu_stall_a, host_gnt_a, host_rvalid_a, sram_en_a, sram_we_a;
  logic [7:0] cpu_rdata_a, host_rdata_a, sram_addr_a, sram_wdata_a, sram_rdata_a;
  logic       cpu_stall_b, host_gnt_b, host_rvalid_b, sram_en_b, sram_we_b;
  logic [7:0] cpu_rdata_b, host_rdata_b, sram_addr_b, sram_wdata_b, sram_rdata_b;

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  oisc_sram_arbiter #(.AW(8), .DW(8), .HOST_BURST(4)) dut_a (
    .clk(clk), .rst(rst),
    .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall_a), .cpu_rdata(cpu_rdata_a),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt_a), .host_rvalid(host_rvalid_a), .host_rdata(host_rdata_a),
    .sram_en(sram_en_a), .sram_we(sram_we_a), .sram_addr(sram_addr_a),
    .sram_wdata(sram_wdata_a), .sram_rdata(sram_rdata_a)
  );

  oisc_sram_arbiter #(.AW(8), .DW(8), .HOST_BURST(1)) dut_b (
    .clk(clk), .rst(rst),
    .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall_b), .cpu_rdata(cpu_rdata_b),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt_b), .host_rvalid(host_rvalid_b), .host_rdata(host_rdata_b),
    .sram_en(sram_en_b), .sram_we(sram_we_b), .sram_addr(sram_addr_b),
    .sram_wdata(sram_wdata_b), .sram_rdata(sram_rdata_b)
  );

  // Behavioural SRAMs; address 0x10 is preloaded with 0x5A while reset is high.
  always @(posedge clk) begin
    if (rst) mem_a[8'h10] <= 8'h5A;
    else if (sram_en_a) begin
      if (sram_we_a) mem_a[sram_addr_a] <= sram_wdata_a;
      else           sram_rdata_a       <= mem_a[sram_addr_a];
    end
  end

  always @(posedge clk) begin
    if (rst) mem_b[8'h10] <= 8'h5A;
    else if (sram_en_b) begin
      if (sram_we_b) mem_b[sram_addr_b] <= sram_wdata_b;
      else           sram_rdata_b       <= mem_b[sram_addr_b];
    end
  end

  task automatic drive(input logic ce, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                       input logic hr, input logic hw, input logic [7:0] ha, input logic [7:0] hd);
    @(negedge clk);
    cpu_en = ce; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_en = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10; cpu_wdata = 8'h00;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h00; host_wdata = 8'h00;
    @(negedge clk); #1;
    checks++; if (sram_en_a !== 1'b0) $display("[TB] FAIL reset_sram_en got=%b exp=0", sram_en_a); else passed++;
    checks++; if (host_gnt_a !== 1'b0) $display("[TB] FAIL reset_host_gnt got=%b exp=0", host_gnt_a); else passed++;
    checks++; if (cpu_stall_a !== 1'b1) $display("[TB] FAIL reset_cpu_stall got=%b exp=1", cpu_stall_a); else passed++;
    checks++; if (host_rvalid_a !== 1'b0) $display("[TB] FAIL reset_rvalid got=%b exp=0", host_rvalid_a); else passed++;
    @(negedge clk);
    rst = 1'b0;
    idle();
  endtask

  task automatic test_cpu_read();
    drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    checks++; if (sram_en_a !== 1'b1) $display("[TB] FAIL cpu_rd_en got=%b exp=1", sram_en_a); else passed++;
    checks++; if (cpu_stall_a !== 1'b0) $display("[TB] FAIL cpu_rd_stall got=%b exp=0", cpu_stall_a); else passed++;
    checks++; if (sram_addr_a !== 8'h10) $display("[TB] FAIL cpu_rd_addr got=%h exp=10", sram_addr_a); else passed++;
    idle();
    checks++; if (cpu_rdata_a !== 8'h5A) $display("[TB] FAIL cpu_rd_data got=%h exp=5a", cpu_rdata_a); else passed++;
    checks++; if (host_rvalid_a !== 1'b0) $display("[TB] FAIL cpu_rd_hvalid got=%b exp=0", host_rvalid_a); else passed++;
  endtask

  task automatic test_host_writes();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'(i), 8'(i + 1));
      checks++; if (host_gnt_a !== 1'b1) $display("[TB] FAIL hwr_gnt[%0d] got=%b exp=1", i, host_gnt_a); else passed++;
      checks++; if (sram_we_a !== 1'b1 || sram_addr_a !== 8'(i) || sram_wdata_a !== 8'(i + 1))
        $display("[TB] FAIL hwr_bus[%0d] got we=%b a=%h d=%h exp we=1 a=%h d=%h",
                 i, sram_we_a, sram_addr_a, sram_wdata_a, 8'(i), 8'(i + 1));
      else passed++;
    end
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00);
    checks++; if (host_gnt_a !== 1'b1) $display("[TB] FAIL hrd_gnt got=%b exp=1", host_gnt_a); else passed++;
    checks++; if (host_rvalid_a !== 1'b0) $display("[TB] FAIL hrd_early_valid got=%b exp=0", host_rvalid_a); else passed++;
    idle();
    checks++; if (host_rvalid_a !== 1'b1) $display("[TB] FAIL hrd_valid got=%b exp=1", host_rvalid_a); else passed++;
    checks++; if (host_rdata_a !== 8'h03) $display("[TB] FAIL hrd_data got=%h exp=03", host_rdata_a); else passed++;
  endtask

  // CPU reads 0x10 (0x5A) and host reads 0x02 (0x03) continuously on both instances.
  task automatic test_contention();
    logic exp_a, exp_b, prev_a, prev_b;
    prev_a = 1'b0; prev_b = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00);
      exp_a = (i % 5) != 4;
      exp_b = (i % 2) == 0;
      checks++; if (host_gnt_a !== exp_a) $display("[TB] FAIL cont4_gnt[%0d] got=%b exp=%b", i, host_gnt_a, exp_a); else passed++;
      checks++; if (cpu_stall_a !== exp_a) $display("[TB] FAIL cont4_stall[%0d] got=%b exp=%b", i, cpu_stall_a, exp_a); else passed++;
      checks++; if (host_gnt_b !== exp_b || cpu_stall_b !== exp_b)
        $display("[TB] FAIL cont1_gnt[%0d] got gnt=%b stall=%b exp=%b", i, host_gnt_b, cpu_stall_b, exp_b);
      else passed++;
      if (i > 0) begin
        checks++; if (host_rvalid_b !== prev_b) $display("[TB] FAIL cont1_rvalid[%0d] got=%b exp=%b", i, host_rvalid_b, prev_b); else passed++;
        checks++;
        if (prev_b ? (host_rdata_b !== 8'h03) : (cpu_rdata_b !== 8'h5A))
          $display("[TB] FAIL cont1_rdata[%0d] got h=%h c=%h exp %s", i, host_rdata_b, cpu_rdata_b, prev_b ? "h=03" : "c=5a");
        else passed++;
        checks++; if (host_rvalid_a !== prev_a) $display("[TB] FAIL cont4_rvalid[%0d] got=%b exp=%b", i, host_rvalid_a, prev_a); else passed++;
      end
      prev_a = exp_a; prev_b = exp_b;
    end
    idle();
    checks++; if (host_rvalid_a !== prev_a) $display("[TB] FAIL cont4_last_rvalid got=%b exp=%b", host_rvalid_a, prev_a); else passed++;
    checks++; if (cpu_rdata_b !== 8'h5A) $display("[TB] FAIL cont1_last_cdata got=%h exp=5a", cpu_rdata_b); else passed++;
  endtask

  task automatic test_reset_mid_read();
    logic exp_a;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h01, 8'h00);
      checks++; if (host_gnt_a !== 1'b1) $display("[TB] FAIL rstmid_pre_gnt[%0d] got=%b exp=1", i, host_gnt_a); else passed++;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (host_rvalid_a !== 1'b0) $display("[TB] FAIL rstmid_rvalid got=%b exp=0", host_rvalid_a); else passed++;
    checks++; if (sram_en_a !== 1'b0 || sram_we_a !== 1'b0 || host_gnt_a !== 1'b0)
      $display("[TB] FAIL rstmid_strobes got en=%b we=%b gnt=%b exp 0", sram_en_a, sram_we_a, host_gnt_a);
    else passed++;
    checks++; if (cpu_stall_a !== 1'b1) $display("[TB] FAIL rstmid_stall got=%b exp=1", cpu_stall_a); else passed++;
    @(negedge clk);
    #1;
    checks++; if (host_rvalid_a !== 1'b0) $display("[TB] FAIL rstmid_rvalid2 got=%b exp=0", host_rvalid_a); else passed++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (host_gnt_a !== 1'b1) $display("[TB] FAIL rstmid_post_gnt[0] got=%b exp=1", host_gnt_a); else passed++;
    for (int i = 1; i < 5; i++) begin
      drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h01, 8'h00);
      exp_a = (i != 4);
      checks++; if (host_gnt_a !== exp_a) $display("[TB] FAIL rstmid_post_gnt[%0d] got=%b exp=%b", i, host_gnt_a, exp_a); else passed++;
    end
    idle();
  endtask

  task automatic test_host_drop();
    logic exp_a;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00);
      checks++; if (host_gnt_a !== 1'b1) $display("[TB] FAIL drop_pre_gnt[%0d] got=%b exp=1", i, host_gnt_a); else passed++;
    end
    drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h02, 8'h00);
    checks++; if (cpu_stall_a !== 1'b0 || host_gnt_a !== 1'b0)
      $display("[TB] FAIL drop_gap got stall=%b gnt=%b exp 0/0", cpu_stall_a, host_gnt_a);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00);
      exp_a = (i != 4);
      checks++; if (host_gnt_a !== exp_a) $display("[TB] FAIL drop_post_gnt[%0d] got=%b exp=%b", i, host_gnt_a, exp_a); else passed++;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_host_writes();
    test_contention();
    test_reset_mid_read();
    test_host_drop();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/oisc_sram_arbiter.md
# oisc_sram_arbiter

Shares the single-port program/data SRAM of the OISC processor between the processor FSM and a host port (program loader / debug reader). It grants one requester per cycle, stalls the processor when the host wins, and routes the SRAM's 1-cycle-latency read data back to the owner of the access. A burst counter bounds host starvation of the processor. The block sits between `processor_fsm`/datapath and the SRAM macro.

## Interface
- `AW`, 8: SRAM address width.
- `DW`, 8: SRAM data width.
- `HOST_BURST`, 4: maximum consecutive contested host grants before the processor is forced a slot; legal range 1..15.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `cpu_en`  in  1  processor access request. Equals the FSM's `sram_en` and is held while `cpu_stall`=1.
- `cpu_we`  in  1  processor write.
- `cpu_addr`  in  AW  processor address.
- `cpu_wdata`  in  DW  processor write data.
- `cpu_stall`  out  1  processor request not granted this cycle; the FSM must hold state.
- `cpu_rdata`  out  DW  read data returned to the processor.
- `host_req`  in  1  host access request; held until `host_gnt`.
- `host_we`, `host_addr` (AW), `host_wdata` (DW)  in  host access fields.
- `host_gnt`  out  1  host access issued this cycle.
- `host_rvalid`  out  1  `host_rdata` valid.
- `host_rdata`  out  DW  read data returned to the host.
- `sram_en`, `sram_we`  out  1  SRAM strobes.
- `sram_addr` (AW), `sram_wdata` (DW)  out  SRAM address and write data.
- `sram_rdata`  in  DW  SRAM read data, valid the cycle after a read strobe.

## Operation
- Registers:
  - `owner_q`: NONE, CPU or HOST; the grant of the previous cycle, with read/write.
  - `hcnt`: 4 bits.
- Grant is combinational from the requests, `hcnt` and `rst`:
  - Only `cpu_en`: grant CPU.
  - Only `host_req`: grant HOST.
  - Both (contested): grant HOST if `hcnt` < HOST_BURST, else grant CPU.
  - Neither: no grant; `sram_en`=0.
- `hcnt` update:
  - Contested HOST grant: +1.
  - Contested CPU grant: clear to 0.
  - Cycle with `host_req`=0: clear to 0.
  - Uncontested host grant: unchanged.
  - Saturates at HOST_BURST.
- SRAM mux: the granted requester's we/addr/wdata drive the SRAM. With no grant, addr/wdata hold the CPU fields and `sram_we`=0.
- `cpu_stall` = `cpu_en` AND NOT cpu-granted.
- `host_gnt` = host-granted.
- Read return, based on `owner_q`:
  - `owner_q`=HOST and the access was a read: `host_rvalid`=1, `host_rdata`=`sram_rdata`.
  - `cpu_rdata` = `sram_rdata` always. It is meaningful only the cycle after a CPU read grant.
- Writes produce no return.

## Timing
- Grant latency is 0 cycles: request and grant occur in the same cycle.
- Read data: the cycle after the grant.
- Back-to-back grants are allowed every cycle, including alternating owners.
- While `rst`=1:
  - Grants are forced off: `sram_en`=0, `sram_we`=0, `host_gnt`=0, `host_rvalid`=0.
  - `cpu_stall`=`cpu_en`.
  - `owner_q`=NONE, `hcnt`=0.
- Reset mid-read: the pending `host_rvalid` is dropped. After `rst` falls, the first grant is allowed on the first edge.
- HOST_BURST=1: grants strictly alternate under continuous contention.
- Simultaneous `cpu_we` and `host_we` to the same address: only the granted write occurs. The loser reissues it later, so the last writer wins in grant order.
- Host deasserting `host_req` without a grant is legal; no state change beyond clearing `hcnt`.

## Test plan
- CPU only, read addr 0x10 (SRAM holds 0x5A): `sram_en`=1 in cycle 0, `cpu_stall`=0, `cpu_rdata`=0x5A in cycle 1, `host_rvalid`=0.
- Host only, writes 0x01..0x04 to addr 0x00..0x03 in consecutive cycles, then reads 0x02: 4 grants without gaps, then `host_rvalid`=1 with 0x03 one cycle after the read grant.
- Continuous contention, HOST_BURST=4: grant pattern H,H,H,H,C,H,H,H,H,C. `cpu_stall`=1 exactly on the H cycles.
- Continuous contention, HOST_BURST=1: grants alternate H,C,H,C. A read by each returns its data to the correct port only.
- `rst` asserted the cycle after a host read grant: `host_rvalid` stays 0. All outputs are 0 except `cpu_stall`=`cpu_en`. `hcnt` restarts so that 4 host grants precede the next CPU grant.
- Host drops `host_req` after 2 contested grants, then reasserts: `hcnt` is cleared, and the next contested run allows 4 host grants.
